// File: rtl/conv1x1_frame_ctrl.sv
// Frame sequencer for the 1x1 convolution stage: issues row-major pixel reads,
// drives conv valid/enable and lines up result writes with the conv output register.
module conv1x1_frame_ctrl #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  conv_valid,
    output logic                  conv_en,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [15:0]           frame_cnt,
    output logic [1:0]            dbg_state
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  drain_cnt;
    logic                  abort_seen;
    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  last_pix;

    // Handshake: there is no backpressure. A read issued with rd_en in cycle t
    // presents data to the conv stage in t+1 (conv_valid) and is written with
    // wr_en/wr_addr in t+2. pause only withholds new reads; it never stalls the slots.
    assign last_pix   = (x == X_LAST) && (y == Y_LAST);
    assign rd_en      = (state == S_FETCH) && !pause;
    assign busy       = (state != S_IDLE);
    assign conv_en    = busy;
    assign done       = (state == S_DONE);
    assign conv_valid = s1_valid;
    assign dbg_state  = state;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            rd_addr    <= '0;
            drain_cnt  <= 1'b0;
            abort_seen <= 1'b0;
            aborted    <= 1'b0;
            frame_cnt  <= '0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
        end else begin
            // Two-slot {valid, addr} shift register tracking each pixel to its write.
            s1_valid <= rd_en;
            s1_addr  <= rd_addr;
            wr_en    <= s1_valid;
            wr_addr  <= s1_addr;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        x          <= '0;
                        y          <= '0;
                        rd_addr    <= '0;
                        aborted    <= 1'b0;
                        abort_seen <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                    if (abort) begin
                        abort_seen <= 1'b1;
                    end
                    // A paused last pixel keeps us here until its read really issues.
                    if (abort || (rd_en && last_pix)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) begin
                        state     <= S_DONE;
                        frame_cnt <= frame_cnt + 16'd1;
                        aborted   <= abort_seen;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv1x1_frame_ctrl.sv
// Directed bench for conv1x1_frame_ctrl on a 4x2 frame; cycle 0 is the cycle
// in which start is presented, outputs are sampled on the falling edge.
module tb_conv1x1_frame_ctrl;

    localparam int IMG_W      = 4;
    localparam int IMG_H      = 2;
    localparam int ADDR_WIDTH = 3;

    logic                  Clk;
    logic                  Rst;
    logic                  start;
    logic                  pause;
    logic                  abort;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  conv_valid;
    logic                  conv_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [15:0]           frame_cnt;
    logic [1:0]            dbg_state;

    int checks;
    int errors;
    logic [15:0] exp_frames;

    conv1x1_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .pause(pause), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .conv_valid(conv_valid), .conv_en(conv_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .aborted(aborted),
        .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Driver: present inputs for one cycle, return at its falling edge.
    task automatic drive_cycle(input logic s, input logic p, input logic a, input logic rstn);
        @(posedge Clk);
        #1;
        start = s;
        pause = p;
        abort = a;
        Rst   = rstn;
        @(negedge Clk);
    endtask

    function automatic int find_idx(input int rc[8], input int n, input int c);
        for (int i = 0; i < n; i++) if (rc[i] == c) return i;
        return -1;
    endfunction

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done timeout: got done=%b after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({rd_en, rd_addr, conv_valid, conv_en, wr_en, wr_addr, busy, done, aborted, frame_cnt, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got rd_en=%b rd_addr=%0d cv=%b en=%b wr_en=%b wr_addr=%0d busy=%b done=%b ab=%b fc=%0d st=%0d, required all 0",
                     rd_en, rd_addr, conv_valid, conv_en, wr_en, wr_addr, busy, done, aborted, frame_cnt, dbg_state);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_basic();
        int rc[8];
        int r, v, w;
        rc = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int c = 0; c <= 13; c++) begin
            drive_cycle(c == 0, 1'b0, 1'b0, 1'b1);
            r = find_idx(rc, 8, c); v = find_idx(rc, 8, c - 1); w = find_idx(rc, 8, c - 2);
            checks++; if (rd_en !== (r >= 0)) begin errors++; $display("FAIL basic rd_en c=%0d: got %b required %b", c, rd_en, r >= 0); end
            if (r >= 0) begin checks++; if (rd_addr !== ADDR_WIDTH'(r)) begin errors++; $display("FAIL basic rd_addr c=%0d: got %0d required %0d", c, rd_addr, r); end end
            checks++; if (conv_valid !== (v >= 0)) begin errors++; $display("FAIL basic conv_valid c=%0d: got %b required %b", c, conv_valid, v >= 0); end
            checks++; if (wr_en !== (w >= 0)) begin errors++; $display("FAIL basic wr_en c=%0d: got %b required %b", c, wr_en, w >= 0); end
            if (w >= 0) begin checks++; if (wr_addr !== ADDR_WIDTH'(w)) begin errors++; $display("FAIL basic wr_addr c=%0d: got %0d required %0d", c, wr_addr, w); end end
            checks++; if (done !== (c == 11)) begin errors++; $display("FAIL basic done c=%0d: got %b required %b", c, done, c == 11); end
            checks++; if (busy !== (c >= 1 && c <= 11)) begin errors++; $display("FAIL basic busy c=%0d: got %b required %b", c, busy, c >= 1 && c <= 11); end
            checks++; if (conv_en !== (c >= 1 && c <= 11)) begin errors++; $display("FAIL basic conv_en c=%0d: got %b required %b", c, conv_en, c >= 1 && c <= 11); end
            if (c == 11) begin
                exp_frames = exp_frames + 16'd1;
                checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL basic frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
            end
        end
    endtask

    task automatic test_pause();
        int rc[8];
        int r, v, w;
        int wr_seen[8];
        rc = '{1, 2, 6, 7, 8, 9, 10, 11};
        for (int i = 0; i < 8; i++) wr_seen[i] = 0;
        for (int c = 0; c <= 16; c++) begin
            drive_cycle(c == 0, c >= 3 && c <= 5, 1'b0, 1'b1);
            r = find_idx(rc, 8, c); v = find_idx(rc, 8, c - 1); w = find_idx(rc, 8, c - 2);
            if (wr_en === 1'b1) wr_seen[wr_addr]++;
            checks++; if (rd_en !== (r >= 0)) begin errors++; $display("FAIL pause rd_en c=%0d: got %b required %b", c, rd_en, r >= 0); end
            if (r >= 0) begin checks++; if (rd_addr !== ADDR_WIDTH'(r)) begin errors++; $display("FAIL pause rd_addr c=%0d: got %0d required %0d", c, rd_addr, r); end end
            checks++; if (conv_valid !== (v >= 0)) begin errors++; $display("FAIL pause conv_valid c=%0d: got %b required %b", c, conv_valid, v >= 0); end
            checks++; if (wr_en !== (w >= 0)) begin errors++; $display("FAIL pause wr_en c=%0d: got %b required %b", c, wr_en, w >= 0); end
            if (w >= 0) begin checks++; if (wr_addr !== ADDR_WIDTH'(w)) begin errors++; $display("FAIL pause wr_addr c=%0d: got %0d required %0d", c, wr_addr, w); end end
            checks++; if (done !== (c == 14)) begin errors++; $display("FAIL pause done c=%0d: got %b required %b", c, done, c == 14); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (wr_seen[i] != 1) begin errors++; $display("FAIL pause write count addr=%0d: got %0d required 1", i, wr_seen[i]); end
        end
        exp_frames = exp_frames + 16'd1;
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL pause frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_abort();
        int rc[8];
        int r, w;
        rc = '{1, 2, 3, 4, 0, 0, 0, 0};
        for (int c = 0; c <= 8; c++) begin
            drive_cycle(c == 0, 1'b0, c == 4, 1'b1);
            r = find_idx(rc, 4, c); w = find_idx(rc, 4, c - 2);
            checks++; if (rd_en !== (r >= 0)) begin errors++; $display("FAIL abort rd_en c=%0d: got %b required %b", c, rd_en, r >= 0); end
            if (r >= 0) begin checks++; if (rd_addr !== ADDR_WIDTH'(r)) begin errors++; $display("FAIL abort rd_addr c=%0d: got %0d required %0d", c, rd_addr, r); end end
            checks++; if (wr_en !== (w >= 0)) begin errors++; $display("FAIL abort wr_en c=%0d: got %b required %b", c, wr_en, w >= 0); end
            if (w >= 0) begin checks++; if (wr_addr !== ADDR_WIDTH'(w)) begin errors++; $display("FAIL abort wr_addr c=%0d: got %0d required %0d", c, wr_addr, w); end end
            checks++; if (done !== (c == 7)) begin errors++; $display("FAIL abort done c=%0d: got %b required %b", c, done, c == 7); end
            checks++; if (aborted !== (c >= 7)) begin errors++; $display("FAIL abort aborted c=%0d: got %b required %b", c, aborted, c >= 7); end
        end
        exp_frames = exp_frames + 16'd1;
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL abort frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (aborted !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort restart: got aborted=%b busy=%b required 0 1", aborted, busy); end
        wait_done(30, "abort restart");
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort full frame aborted: got %b required 0", aborted); end
        exp_frames = exp_frames + 16'd1;
    endtask

    task automatic test_start_ignored();
        int rd_cnt;
        rd_cnt = 0;
        for (int c = 0; c <= 16; c++) begin
            drive_cycle(c == 0 || c == 3 || c == 9 || c == 10, 1'b0, 1'b0, 1'b1);
            if (rd_en === 1'b1) rd_cnt++;
            checks++; if (done !== (c == 11)) begin errors++; $display("FAIL start_ignored done c=%0d: got %b required %b", c, done, c == 11); end
            checks++; if (busy !== (c >= 1 && c <= 11)) begin errors++; $display("FAIL start_ignored busy c=%0d: got %b required %b", c, busy, c >= 1 && c <= 11); end
        end
        checks++; if (rd_cnt != 8) begin errors++; $display("FAIL start_ignored read count: got %0d required 8", rd_cnt); end
        exp_frames = exp_frames + 16'd1;
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL start_ignored frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        wait_done(20, "b2b first");
        exp_frames = exp_frames + 16'd1;
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL b2b first frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b idle gap busy: got %b required 0", busy); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== '0) begin errors++; $display("FAIL b2b second start: got busy=%b rd_en=%b rd_addr=%0d required 1 1 0", busy, rd_en, rd_addr); end
        wait_done(20, "b2b second");
        exp_frames = exp_frames + 16'd1;
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL b2b second frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        for (int c = 0; c <= 10; c++) begin
            drive_cycle(c == 0, 1'b0, 1'b0, c != 5);
            if (c == 6) begin
                checks++;
                if ({rd_en, rd_addr, conv_valid, conv_en, wr_en, wr_addr, busy, done, aborted, frame_cnt, dbg_state} !== '0) begin
                    errors++;
                    $display("FAIL reset_mid outputs: got rd_en=%b rd_addr=%0d cv=%b wr_en=%b wr_addr=%0d busy=%b done=%b fc=%0d st=%0d, required all 0",
                             rd_en, rd_addr, conv_valid, wr_en, wr_addr, busy, done, frame_cnt, dbg_state);
                end
            end
            if (c >= 6) begin
                checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid quiet c=%0d: got wr_en=%b busy=%b required 0 0", c, wr_en, busy); end
            end
        end
        exp_frames = 16'd0;
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL reset_mid frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_wrap();
        force dut.frame_cnt = 16'hFFFF;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        release dut.frame_cnt;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        wait_done(20, "wrap");
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap frame_cnt: got %0d required 0", frame_cnt); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_frames = 16'd0;
        Rst   = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        test_reset();
        test_basic();
        test_pause();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
